// File: rtl/stream_lead_zero_counter.sv
// Streaming leading-run counter: accumulates a unary prefix (zeros, or ones in
// mode 1) across beats and emits one result per terminated or ended run.
module stream_lead_zero_counter #(
  parameter int W_IN  = 8,
  parameter int W_CNT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_IN-1:0]          in_data,
  input  logic                     in_mode,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W_CNT-1:0]         out_count,
  output logic [$clog2(W_IN)-1:0]  out_pos,
  output logic                     out_unterminated,
  output logic                     out_overflow
);

  localparam int LW = $clog2(W_IN);
  localparam logic [W_CNT:0] BEAT_BITS = (W_CNT+1)'(W_IN);

  // Handshake: a beat moves on in_valid && in_ready, a result on
  // out_valid && out_ready; both sides hold their payload until that cycle.

  // Halving tree: at each level test whether the upper half of the current
  // window is empty; if so record the bit and slide the lower half up.
  function automatic logic [LW-1:0] lead_zeros(input logic [W_IN-1:0] d);
    logic [W_IN-1:0] v;
    logic [W_IN-1:0] top;
    logic [LW-1:0]   z;
    logic            hit;
    v = d;
    z = '0;
    for (int l = LW - 1; l >= 0; l--) begin
      top = ~({W_IN{1'b1}} >> (1 << l));
      hit = ((v & top) == '0);
      z   = (z << 1) | LW'(hit);
      if (hit) v = v << (1 << l);
    end
    return z;
  endfunction

  // Returns {saturated, clamped_sum}.
  function automatic logic [W_CNT:0] add_sat(input logic [W_CNT-1:0] a,
                                             input logic [W_CNT:0]   inc);
    logic [W_CNT:0] sum;
    sum = {1'b0, a} + inc;
    if (sum[W_CNT]) return {1'b1, {W_CNT{1'b1}}};
    return sum;
  endfunction

  logic [W_IN-1:0] beat;
  logic [LW-1:0]   beat_z;
  logic            beat_all;

  logic            s1_valid;
  logic [LW-1:0]   s1_z;
  logic            s1_all;
  logic            s1_last;

  logic [W_CNT-1:0] acc;
  logic             ovf;

  logic             s1_produces;
  logic             s1_advance;
  logic [W_CNT:0]   s1_inc;
  logic [W_CNT:0]   sum_sat;

  // Mode 1 is handled by inverting the beat so the tree always counts zeros.
  assign beat     = in_mode ? ~in_data : in_data;
  assign beat_z   = lead_zeros(beat);
  assign beat_all = (beat == '0);

  assign s1_produces = s1_valid && (!s1_all || s1_last);
  assign s1_advance  = s1_valid && (!s1_produces || !out_valid || out_ready);
  assign in_ready    = !flush && (!s1_valid || s1_advance);

  assign s1_inc  = s1_all ? BEAT_BITS : (W_CNT+1)'(s1_z);
  assign sum_sat = add_sat(acc, s1_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_z     <= '0;
      s1_all   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_z     <= '0;
      s1_all   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_z     <= beat_z;
      s1_all   <= beat_all;
      s1_last  <= in_last;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc              <= '0;
      ovf              <= 1'b0;
      out_valid        <= 1'b0;
      out_count        <= '0;
      out_pos          <= '0;
      out_unterminated <= 1'b0;
      out_overflow     <= 1'b0;
    end else if (flush) begin
      acc              <= '0;
      ovf              <= 1'b0;
      out_valid        <= 1'b0;
      out_count        <= '0;
      out_pos          <= '0;
      out_unterminated <= 1'b0;
      out_overflow     <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (s1_advance) begin
        if (s1_produces) begin
          // A new result may overwrite one popped this same cycle.
          out_valid        <= 1'b1;
          out_count        <= sum_sat[W_CNT-1:0];
          out_pos          <= s1_all ? '0 : s1_z;
          out_unterminated <= s1_all;
          out_overflow     <= ovf | sum_sat[W_CNT];
          acc              <= '0;
          ovf              <= 1'b0;
        end else begin
          acc <= sum_sat[W_CNT-1:0];
          ovf <= ovf | sum_sat[W_CNT];
        end
      end
    end
  end

endmodule
